// File: rtl/inst_sram_resp.sv
// Single-port instruction SRAM responder: one-cycle registered read, read-first
// byte writes, address-window decode with sticky error capture and access counters.
module inst_sram_resp #(
    parameter int unsigned DEPTH_LOG2 = 16,
    parameter logic [31:0] BASE_ADDR  = 32'h1c00_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        inst_sram_en,
    input  logic [3:0]  inst_sram_we,
    input  logic [31:0] inst_sram_addr,
    input  logic [31:0] inst_sram_wdata,
    output logic [31:0] inst_sram_rdata,
    output logic        range_err,
    output logic [31:0] err_addr,
    output logic [31:0] rd_cnt,
    output logic [31:0] wr_cnt
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

    logic [31:0]           mem [DEPTH];
    logic [31:0]           off;
    logic [DEPTH_LOG2-1:0] idx;
    logic                  in_win;
    logic                  acc_ok;
    logic                  acc_oor;
    logic                  mem_wr;
    logic [31:0]           mem_rdata;
    logic                  unused_off_lsbs;

    logic [31:0] rdata_q, rdata_d;
    logic        range_err_q, range_err_d;
    logic [31:0] err_addr_q, err_addr_d;
    logic [31:0] rd_cnt_q, rd_cnt_d;
    logic [31:0] wr_cnt_q, wr_cnt_d;

    // Addresses below BASE_ADDR wrap to a huge offset and fall out of window.
    assign off             = inst_sram_addr - BASE_ADDR;
    assign idx             = off[DEPTH_LOG2+1:2];
    assign in_win          = (off >> (DEPTH_LOG2 + 2)) == '0;
    assign unused_off_lsbs = ^off[1:0];

    assign acc_ok    = inst_sram_en && in_win;
    assign acc_oor   = inst_sram_en && !in_win;
    assign mem_wr    = acc_ok && (inst_sram_we != 4'b0000) && !reset;
    assign mem_rdata = mem[idx];

    // NOTE: the array has no reset branch so it maps onto block RAM; contents survive reset.
    always_ff @(posedge clk) begin
        if (mem_wr) begin
            for (int b = 0; b < 4; b++) begin
                if (inst_sram_we[b]) begin
                    mem[idx][8*b +: 8] <= inst_sram_wdata[8*b +: 8];
                end
            end
        end
    end

    // NOTE: every variable gets a hold default first so no path leaves it unassigned (no latch).
    always_comb begin
        rdata_d     = rdata_q;
        range_err_d = range_err_q;
        err_addr_d  = err_addr_q;
        rd_cnt_d    = rd_cnt_q;
        wr_cnt_d    = wr_cnt_q;
        if (acc_ok) begin
            rdata_d = mem_rdata;
            if (inst_sram_we == 4'b0000) begin
                rd_cnt_d = rd_cnt_q + 32'd1;
            end else begin
                wr_cnt_d = wr_cnt_q + 32'd1;
            end
        end else if (acc_oor) begin
            rdata_d = '0;
            if (!range_err_q) begin
                range_err_d = 1'b1;
                err_addr_d  = inst_sram_addr;
            end
        end
    end

    // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of order.
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata_q     <= '0;
            range_err_q <= 1'b0;
            err_addr_q  <= '0;
            rd_cnt_q    <= '0;
            wr_cnt_q    <= '0;
        end else begin
            rdata_q     <= rdata_d;
            range_err_q <= range_err_d;
            err_addr_q  <= err_addr_d;
            rd_cnt_q    <= rd_cnt_d;
            wr_cnt_q    <= wr_cnt_d;
        end
    end

    assign inst_sram_rdata = rdata_q;
    assign range_err       = range_err_q;
    assign err_addr        = err_addr_q;
    assign rd_cnt          = rd_cnt_q;
    assign wr_cnt          = wr_cnt_q;

endmodule

// File: tb/tb_inst_sram_resp.sv
// Self-checking bench for inst_sram_resp: table of access vectors plus hand-written
// reset/wrap sequences; expectations go through a one-deep-latency scoreboard queue.
module tb_inst_sram_resp;

    localparam logic [31:0] BASE = 32'h1c00_0000;

    typedef struct {
        logic        chk_rdata;
        logic [31:0] rdata;
        logic [31:0] rd_cnt;
        logic [31:0] wr_cnt;
        logic        range_err;
        logic [31:0] err_addr;
    } exp_t;

    typedef struct {
        logic        en;
        logic [3:0]  we;
        logic [31:0] addr;
        logic [31:0] wdata;
        exp_t        exp;
    } vec_t;

    logic        clk;
    logic        reset;
    logic        inst_sram_en;
    logic [3:0]  inst_sram_we;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;
    logic [31:0] inst_sram_rdata;
    logic        range_err;
    logic [31:0] err_addr;
    logic [31:0] rd_cnt;
    logic [31:0] wr_cnt;

    int   tests;
    int   fails;
    exp_t sb[$];
    vec_t vecs[$];

    inst_sram_resp #(.DEPTH_LOG2(16), .BASE_ADDR(BASE)) dut (
        .clk             (clk),
        .reset           (reset),
        .inst_sram_en    (inst_sram_en),
        .inst_sram_we    (inst_sram_we),
        .inst_sram_addr  (inst_sram_addr),
        .inst_sram_wdata (inst_sram_wdata),
        .inst_sram_rdata (inst_sram_rdata),
        .range_err       (range_err),
        .err_addr        (err_addr),
        .rd_cnt          (rd_cnt),
        .wr_cnt          (wr_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic exp_t mk_exp(input logic chk, input logic [31:0] rdata,
                                    input logic [31:0] rdc, input logic [31:0] wrc,
                                    input logic rerr, input logic [31:0] eaddr);
        exp_t e;
        e.chk_rdata = chk;
        e.rdata     = rdata;
        e.rd_cnt    = rdc;
        e.wr_cnt    = wrc;
        e.range_err = rerr;
        e.err_addr  = eaddr;
        return e;
    endfunction

    function automatic vec_t mk_vec(input logic en, input logic [3:0] we,
                                    input logic [31:0] addr, input logic [31:0] wdata,
                                    input exp_t e);
        vec_t v;
        v.en    = en;
        v.we    = we;
        v.addr  = addr;
        v.wdata = wdata;
        v.exp   = e;
        return v;
    endfunction

    task automatic drive(input logic en, input logic [3:0] we,
                         input logic [31:0] addr, input logic [31:0] wdata);
        inst_sram_en    = en;
        inst_sram_we    = we;
        inst_sram_addr  = addr;
        inst_sram_wdata = wdata;
    endtask

    // Advance one edge, then pop the expectation for that edge and compare.
    task automatic tick_and_check(input string tag);
        exp_t e;
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL %s scoreboard: got empty queue, expected an entry", tag);
        end else begin
            e = sb.pop_front();
            if (e.chk_rdata) check({tag, " rdata"}, inst_sram_rdata, e.rdata);
            check({tag, " rd_cnt"}, rd_cnt, e.rd_cnt);
            check({tag, " wr_cnt"}, wr_cnt, e.wr_cnt);
            check({tag, " range_err"}, {31'd0, range_err}, {31'd0, e.range_err});
            check({tag, " err_addr"}, err_addr, e.err_addr);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        reset = 1'b1;
        drive(1'b1, 4'hF, BASE, 32'hDEAD_BEEF);

        // Reset held two cycles with a write pending: all outputs zero, write dropped.
        for (int i = 0; i < 2; i++) begin
            sb.push_back(mk_exp(1'b1, 32'd0, 32'd0, 32'd0, 1'b0, 32'd0));
            tick_and_check($sformatf("reset%0d", i));
        end
        reset = 1'b0;
        drive(1'b1, 4'h0, BASE, 32'd0);
        sb.push_back(mk_exp(1'b0, 32'd0, 32'd1, 32'd0, 1'b0, 32'd0));
        tick_and_check("post_reset_read");
        tests++;
        if (inst_sram_rdata === 32'hDEAD_BEEF) begin
            fails++;
            $display("FAIL reset_drop_write: got %h, expected any value but deadbeef",
                     inst_sram_rdata);
        end

        // Preload words 0..3 and word 4 through the port.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 4'hF, BASE + 32'(4 * i), 32'h0280_0000 + 32'(i));
            sb.push_back(mk_exp(1'b0, 32'd0, 32'd1, 32'(i + 1), 1'b0, 32'd0));
            tick_and_check($sformatf("preload%0d", i));
        end
        drive(1'b1, 4'hF, BASE + 32'h10, 32'h1122_3344);
        sb.push_back(mk_exp(1'b0, 32'd0, 32'd1, 32'd5, 1'b0, 32'd0));
        tick_and_check("preload4");

        reset = 1'b1;
        drive(1'b0, 4'h0, 32'd0, 32'd0);
        sb.push_back(mk_exp(1'b1, 32'd0, 32'd0, 32'd0, 1'b0, 32'd0));
        tick_and_check("reset2");
        reset = 1'b0;

        // Sequential fetch
        for (int i = 0; i < 4; i++)
            vecs.push_back(mk_vec(1'b1, 4'h0, BASE + 32'(4 * i), 32'd0,
                                  mk_exp(1'b1, 32'h0280_0000 + 32'(i), 32'(i + 1), 32'd0, 1'b0, 32'd0)));
        // Hold
        vecs.push_back(mk_vec(1'b1, 4'h0, BASE + 32'h8, 32'd0,
                              mk_exp(1'b1, 32'h0280_0002, 32'd5, 32'd0, 1'b0, 32'd0)));
        for (int i = 0; i < 5; i++)
            vecs.push_back(mk_vec(1'b0, 4'h0, BASE + 32'h4, 32'hFFFF_FFFF,
                                  mk_exp(1'b1, 32'h0280_0002, 32'd5, 32'd0, 1'b0, 32'd0)));
        // Byte write: bytes 0 and 2 take DD and BB; write cycle returns the old word.
        vecs.push_back(mk_vec(1'b1, 4'b0101, BASE + 32'h10, 32'hAABB_CCDD,
                              mk_exp(1'b1, 32'h1122_3344, 32'd5, 32'd1, 1'b0, 32'd0)));
        vecs.push_back(mk_vec(1'b1, 4'h0, BASE + 32'h10, 32'd0,
                              mk_exp(1'b1, 32'h11BB_33DD, 32'd6, 32'd1, 1'b0, 32'd0)));
        // Window edges
        vecs.push_back(mk_vec(1'b1, 4'hF, 32'h1c03_fffc, 32'hCAFE_F00D,
                              mk_exp(1'b0, 32'd0, 32'd6, 32'd2, 1'b0, 32'd0)));
        vecs.push_back(mk_vec(1'b1, 4'h0, 32'h1c03_fffc, 32'd0,
                              mk_exp(1'b1, 32'hCAFE_F00D, 32'd7, 32'd2, 1'b0, 32'd0)));
        vecs.push_back(mk_vec(1'b1, 4'h0, 32'h1c04_0000, 32'd0,
                              mk_exp(1'b1, 32'd0, 32'd7, 32'd2, 1'b1, 32'h1c04_0000)));
        vecs.push_back(mk_vec(1'b1, 4'h0, 32'h1c03_fffc, 32'd0,
                              mk_exp(1'b1, 32'hCAFE_F00D, 32'd8, 32'd2, 1'b1, 32'h1c04_0000)));
        vecs.push_back(mk_vec(1'b1, 4'h0, 32'h1bff_fffc, 32'd0,
                              mk_exp(1'b1, 32'd0, 32'd8, 32'd2, 1'b1, 32'h1c04_0000)));
        // 0x1bfffffc aliases word 0xFFFF by its low offset bits; it must not be written.
        vecs.push_back(mk_vec(1'b1, 4'hF, 32'h1bff_fffc, 32'h1234_5678,
                              mk_exp(1'b1, 32'd0, 32'd8, 32'd2, 1'b1, 32'h1c04_0000)));
        vecs.push_back(mk_vec(1'b1, 4'h0, 32'h1c03_fffc, 32'd0,
                              mk_exp(1'b1, 32'hCAFE_F00D, 32'd9, 32'd2, 1'b1, 32'h1c04_0000)));
        vecs.push_back(mk_vec(1'b0, 4'h0, 32'h1c04_0000, 32'd0,
                              mk_exp(1'b1, 32'hCAFE_F00D, 32'd9, 32'd2, 1'b1, 32'h1c04_0000)));
        vecs.push_back(mk_vec(1'b1, 4'h0, BASE, 32'd0,
                              mk_exp(1'b1, 32'h0280_0000, 32'd10, 32'd2, 1'b1, 32'h1c04_0000)));

        foreach (vecs[i]) begin
            drive(vecs[i].en, vecs[i].we, vecs[i].addr, vecs[i].wdata);
            sb.push_back(vecs[i].exp);
            tick_and_check($sformatf("vec%0d", i));
        end

        // Counter wrap
        drive(1'b0, 4'h0, 32'd0, 32'd0);
        @(negedge clk);
        force dut.rd_cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.rd_cnt_q;
        #1;
        check("wrap preset rd_cnt", rd_cnt, 32'hFFFF_FFFF);
        drive(1'b1, 4'h0, BASE + 32'h4, 32'd0);
        sb.push_back(mk_exp(1'b1, 32'h0280_0001, 32'd0, 32'd2, 1'b1, 32'h1c04_0000));
        tick_and_check("wrap");

        // Reset beats a simultaneous write; memory survives reset.
        reset = 1'b1;
        drive(1'b1, 4'hF, BASE, 32'hDEAD_BEEF);
        sb.push_back(mk_exp(1'b1, 32'd0, 32'd0, 32'd0, 1'b0, 32'd0));
        tick_and_check("reset_prio");
        reset = 1'b0;
        drive(1'b1, 4'h0, BASE, 32'd0);
        sb.push_back(mk_exp(1'b1, 32'h0280_0000, 32'd1, 32'd0, 1'b0, 32'd0));
        tick_and_check("after_reset_prio");

        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: got %0d entries, expected 0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
